gpio_bus_ctrl: RTL and testbench



---
 rtl/gpio_bus_pkg.sv | 21 ++
 rtl/gpio_bus_ctrl.sv | 131 +++++++++++++
 tb/tb_gpio_bus_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_bus_pkg.sv
// Shared definitions for the GPIO bus-side master: controller states,
// register offsets relative to the block base, and the default base address.
package gpio_bus_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_WRITE,
      S_READ,
      S_DONE,
      S_ERR
   } state_t;

   // Register offsets from the peripheral base address.
   localparam int unsigned REG_IN  = 0;
   localparam int unsigned REG_OUT = 1;
   localparam int unsigned REG_DIR = 2;

   localparam logic [7:0] DEFAULT_BASE_ADDR = 8'h04;

endpackage

// File: rtl/gpio_bus_ctrl.sv
// Bus-side master for the GPIO peripheral. Turns a 4-phase CPU req/ack
// transaction into the peripheral's pin-level protocol (address bus,
// tri-state data bus, Read_In / Load_Out / Load_DIR strobes) and returns
// read data plus an error flag for illegal accesses.
module gpio_bus_ctrl
   import gpio_bus_pkg::*;
#(
   parameter int unsigned           DATA_W      = 16,
   parameter int unsigned           ADDR_W      = 8,
   parameter logic [ADDR_W-1:0]     BASE_ADDR   = ADDR_W'(DEFAULT_BASE_ADDR),
   parameter int unsigned           WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic              cpu_err,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] addressbus,
   inout  wire  [DATA_W-1:0] databus,
   output logic              Read_In,
   output logic              Load_Out,
   output logic              Load_DIR
);

   state_t            state_q;
   state_t            state_d;
   logic              we_q;
   logic [DATA_W-1:0] wdata_q;
   logic [2:0]        wait_q;
   logic              ack_sent_q;

   // Register selection is decoded from the address latched at request time,
   // which is also what is presented on addressbus.
   logic [ADDR_W-1:0] offset;
   logic              hit_in;
   logic              hit_out;
   logic              hit_dir;

   assign offset  = addressbus - BASE_ADDR;
   assign hit_in  = (offset == ADDR_W'(REG_IN));
   assign hit_out = (offset == ADDR_W'(REG_OUT));
   assign hit_dir = (offset == ADDR_W'(REG_DIR));

   // The data bus is only ever driven while the WRITE cycle is active; async
   // reset clears the state, so the drive drops immediately.
   assign databus = (state_q == S_WRITE) ? wdata_q : {DATA_W{1'bz}};

   // State register.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state decode and strobe/handshake outputs.
   // NOTE: every output gets a default first so no path through the case
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d  = state_q;
      busy     = (state_q != S_IDLE);
      cpu_ack  = 1'b0;
      cpu_err  = 1'b0;
      Read_In  = 1'b0;
      Load_Out = 1'b0;
      Load_DIR = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cpu_req) state_d = S_DECODE;
         end
         S_DECODE: begin
            if (we_q && (hit_out || hit_dir)) state_d = S_WRITE;
            else if (!we_q && hit_in)         state_d = S_READ;
            else                              state_d = S_ERR;
         end
         S_WRITE: begin
            Load_Out = hit_out;
            Load_DIR = hit_dir;
            state_d  = S_DONE;
         end
         S_READ: begin
            Read_In = 1'b1;
            if (wait_q == 3'd0) state_d = S_DONE;
         end
         S_DONE, S_ERR: begin
            // First cycle pulses ack; later cycles wait for cpu_req to drop.
            cpu_ack = !ack_sent_q;
            cpu_err = (state_q == S_ERR) && !ack_sent_q;
            if (!cpu_req) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Request capture, read settle counter, ack sub-phase flag and read data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_q       <= 1'b0;
         wdata_q    <= '0;
         addressbus <= '0;
         wait_q     <= 3'd0;
         ack_sent_q <= 1'b0;
         cpu_rdata  <= '0;
      end else begin
         if (state_q == S_IDLE && cpu_req) begin
            we_q       <= cpu_we;
            wdata_q    <= cpu_wdata;
            addressbus <= cpu_addr;
         end

         if (state_q == S_DECODE)
            wait_q <= 3'(WAIT_CYCLES);
         else if (state_q == S_READ && wait_q != 3'd0)
            wait_q <= wait_q - 3'd1;

         ack_sent_q <= (state_q == S_DONE || state_q == S_ERR) && (state_d == state_q);

         // Capture the bus exactly as seen, X/Z included, on the last READ edge.
         if (state_q == S_READ && wait_q == 3'd0)
            cpu_rdata <= databus;
         else if (state_q == S_DECODE && state_d == S_ERR)
            cpu_rdata <= '0;
      end
   end

endmodule

// File: tb/tb_gpio_bus_ctrl.sv
// Self-checking bench for gpio_bus_ctrl. A transaction-level model expands
// each CPU request into the expected per-cycle pin timeline (from the
// latency rules: write ack at k+3, read at k+3+WAIT, error at k+2) and a
// single compare process checks the DUT against it on every falling edge.
module tb_gpio_bus_ctrl;

   localparam int         DW   = 16;
   localparam int         AW   = 8;
   localparam logic [7:0] BASE = 8'h04;
   localparam int         W    = 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          cpu_ack;
   logic          cpu_err;
   logic [DW-1:0] cpu_rdata;
   logic          busy;
   logic [AW-1:0] addressbus;
   wire  [DW-1:0] databus;
   logic          Read_In;
   logic          Load_Out;
   logic          Load_DIR;

   // Peripheral side: pins drive the bus during reads; registers load on strobes.
   logic          tb_drv_en = 1'b0;
   logic [DW-1:0] tb_drv_val = '0;
   logic [DW-1:0] r_out = '0;
   logic [DW-1:0] r_dir = '0;

   assign databus = tb_drv_en ? tb_drv_val : {DW{1'bz}};

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (Load_Out) r_out <= databus;
      if (Load_DIR) r_dir <= databus;
   end

   gpio_bus_ctrl #(
      .DATA_W     (DW),
      .ADDR_W     (AW),
      .BASE_ADDR  (BASE),
      .WAIT_CYCLES(W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ack   (cpu_ack),
      .cpu_err   (cpu_err),
      .cpu_rdata (cpu_rdata),
      .busy      (busy),
      .addressbus(addressbus),
      .databus   (databus),
      .Read_In   (Read_In),
      .Load_Out  (Load_Out),
      .Load_DIR  (Load_DIR)
   );

   int n_vec  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One expected cycle of the pin-level timeline.
   typedef struct {
      logic          busy;
      logic          ack;
      logic          err;
      logic          rd_in;
      logic          ld_out;
      logic          ld_dir;
      logic          chk_bus;
      logic          tb_drive;
      logic [AW-1:0] addr;
      logic [DW-1:0] bus;
      logic [DW-1:0] rdata;
      logic [DW-1:0] r_out;
      logic [DW-1:0] r_dir;
   } exp_t;

   exp_t exp_q[$];
   exp_t idle_e = '{default: '0};

   // Compare process: one expected cycle per falling edge; idle when empty.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            idle_e.addr  = e.addr;
            idle_e.rdata = e.rdata;
            idle_e.r_out = e.r_out;
            idle_e.r_dir = e.r_dir;
         end else begin
            e = idle_e;
         end
         tb_drv_en  = e.tb_drive;
         tb_drv_val = e.bus;
         #1;
         check("busy",       32'(busy),       32'(e.busy));
         check("cpu_ack",    32'(cpu_ack),    32'(e.ack));
         check("cpu_err",    32'(cpu_err),    32'(e.err));
         check("Read_In",    32'(Read_In),    32'(e.rd_in));
         check("Load_Out",   32'(Load_Out),   32'(e.ld_out));
         check("Load_DIR",   32'(Load_DIR),   32'(e.ld_dir));
         check("addressbus", 32'(addressbus), 32'(e.addr));
         check("cpu_rdata",  32'(cpu_rdata),  32'(e.rdata));
         check("r_out",      32'(r_out),      32'(e.r_out));
         check("r_dir",      32'(r_dir),      32'(e.r_dir));
         if (e.chk_bus) check("databus", 32'(databus), 32'(e.bus));
      end
   end

   // Issue one 4-phase request; the CPU drops req h cycles after the ack cycle.
   task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [DW-1:0] pins, input int h);
      logic [AW-1:0] off;
      exp_t          base;
      exp_t          e;
      int            lat;
      off = addr - BASE;
      @(posedge clk); #1;
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      @(posedge clk); #1;   // request sampled on this edge (edge k)
      base      = idle_e;
      base.busy = 1'b1;
      base.addr = addr;
      exp_q.push_back(base);          // DECODE
      if (we && (off == 8'd1 || off == 8'd2)) begin
         e         = base;
         e.ld_out  = (off == 8'd1);
         e.ld_dir  = (off == 8'd2);
         e.chk_bus = 1'b1;
         e.bus     = wdata;
         exp_q.push_back(e);          // WRITE
         e = base;
         if (off == 8'd1) e.r_out = wdata;
         else             e.r_dir = wdata;
         lat = 2;
      end else if (!we && off == 8'd0) begin
         for (int i = 0; i <= W; i++) begin
            e          = base;
            e.rd_in    = 1'b1;
            e.tb_drive = 1'b1;
            e.chk_bus  = 1'b1;
            e.bus      = pins;
            exp_q.push_back(e);       // READ
         end
         e       = base;
         e.rdata = pins;
         lat     = 2 + W;
      end else begin
         e       = base;
         e.rdata = '0;
         e.err   = 1'b1;
         lat     = 1;
      end
      e.ack = 1'b1;
      exp_q.push_back(e);             // DONE / ERR ack cycle
      e.ack = 1'b0;
      e.err = 1'b0;
      for (int i = 0; i < h; i++) exp_q.push_back(e);   // wait sub-phase
      // Inputs after the accepting edge must be ignored.
      cpu_we    = 1'($urandom);
      cpu_addr  = 8'($urandom);
      cpu_wdata = 16'($urandom);
      repeat (lat + h) @(posedge clk);
      #1;
      cpu_req = 1'b0;
   endtask

   initial begin
      logic [AW-1:0] a;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy",  32'(busy),       32'd0);
      check("rst_ack",   32'(cpu_ack),    32'd0);
      check("rst_addr",  32'(addressbus), 32'd0);
      check("rst_rdata", 32'(cpu_rdata),  32'd0);
      reset = 1'b0;

      run_txn(1'b1, 8'h06, 16'hFFFF, 16'h0000, 0);
      check("lit_r_dir", 32'(r_dir), 32'h0000_FFFF);
      run_txn(1'b1, 8'h05, 16'h0008, 16'h0000, 1);
      check("lit_r_out", 32'(r_out), 32'h0000_0008);
      run_txn(1'b0, 8'h04, 16'h1234, 16'h0003, 0);
      check("lit_rdata_in", 32'(cpu_rdata), 32'h0000_0003);
      run_txn(1'b1, 8'h04, 16'hAAAA, 16'h0000, 2);
      check("lit_err_rdata", 32'(cpu_rdata), 32'd0);
      run_txn(1'b0, 8'h04, 16'h0000, 16'h5555, 0);
      run_txn(1'b0, 8'h10, 16'h0000, 16'h0000, 0);
      check("lit_err2_rdata", 32'(cpu_rdata), 32'd0);

      // Reset asserted in the middle of the WRITE cycle.
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = BASE + 8'd1; cpu_wdata = 16'h5A5A;
      @(posedge clk); #1;
      begin
         exp_t e;
         e      = idle_e;
         e.busy = 1'b1;
         e.addr = BASE + 8'd1;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      check("mid_ld_out", 32'(Load_Out), 32'd1);
      check("mid_bus",    32'(databus),  32'h0000_5A5A);
      #1;
      reset = 1'b1;
      exp_q.delete();
      idle_e.addr  = '0;
      idle_e.rdata = '0;
      cpu_req = 1'b0;
      #1;
      check("rst_mid_ld_out", 32'(Load_Out), 32'd0);
      check("rst_mid_busy",   32'(busy),     32'd0);
      check("rst_mid_ack",    32'(cpu_ack),  32'd0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      check("rst_mid_no_load", 32'(r_out), 32'h0000_0008);
      run_txn(1'b1, 8'h05, 16'hC3C3, 16'h0000, 0);
      check("lit_after_rst", 32'(r_out), 32'h0000_C3C3);

      // Randomized traffic around the mapped window plus random addresses.
      for (int n = 0; n < 60; n++) begin
         int sel;
         sel = int'($urandom_range(0, 5));
         a = (sel == 5) ? 8'($urandom) : BASE - 8'd1 + 8'(sel);
         run_txn(1'($urandom), a, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      repeat (3) @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
